// File: rtl/addr8u_share_ctrl.sv
// rtl/addr8u_share_ctrl.sv - round-robin sharing of one external 8-bit adder among four requesters
// Optional feature macro: ADDR8U_TEMPORAL_REDUNDANCY_EN (compute each sum twice with swapped
// operands, compare, and retry up to MAX_RETRY times before flagging rsp_err).
module addr8u_share_ctrl #(
  parameter int MAX_RETRY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [3:0]  req_ready,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  input  logic [8:0]  add_sum,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [8:0]  rsp_sum,
  output logic        rsp_err,
  output logic        busy,
  output logic [7:0]  fault_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] rr;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       grant;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] op_id;
  logic [8:0] held_sum;
  logic [1:0] held_id;
  logic       held_err;

  // The retry budget only has meaning when non-negative; nothing is built for other values
  if (MAX_RETRY < 0) begin : g_max_retry_negative
  end

`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [8:0]         r1;
  logic [RETRY_W-1:0] retry;
  logic [7:0]         fault_count;
  logic               mismatch;
  logic               retry_left;

  // The second result is compared as it arrives from the adder, so it needs no register
  assign mismatch   = (state == EXEC2) && (add_sum != r1);
  assign retry_left = int'(retry) < MAX_RETRY;
  assign fault_cnt  = fault_count;
`else
  assign fault_cnt  = 8'd0;
`endif

  // Round-robin search for the first valid requester starting at the rr pointer
  always_comb begin
    found = 1'b0;
    win   = rr;
    idx   = rr;
    for (int i = 0; i < 4; i++) begin
      idx = rr + 2'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // A grant is only offered while idle and out of reset, so at most one is in flight
  assign grant     = (state == IDLE) && !rst && found;
  assign req_ready = grant ? (4'b0001 << win) : 4'b0000;

  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_sum   = held_sum;
  assign rsp_id    = held_id;
  assign rsp_err   = held_err;

  // Next-state and adder operand steering; operands rest at zero outside the execute states
  always_comb begin
    state_nx = state;
    add_a    = 8'd0;
    add_b    = 8'd0;
    case (state)
      IDLE: begin
        if (grant) state_nx = EXEC1;
      end
      EXEC1: begin
        add_a = op_a;
        add_b = op_b;
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
        state_nx = EXEC2;
`else
        state_nx = RESP;
`endif
      end
      EXEC2: begin
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
        add_a = op_b;
        add_b = op_a;
        if (!mismatch)       state_nx = RESP;
        else if (retry_left) state_nx = EXEC1;
        else                 state_nx = RESP;
`else
        state_nx = IDLE;
`endif
      end
      RESP: begin
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register; reset aborts whatever transaction is in flight
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, arbitration pointer and response holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr       <= 2'd0;
      op_a     <= 8'd0;
      op_b     <= 8'd0;
      op_id    <= 2'd0;
      held_sum <= 9'd0;
      held_id  <= 2'd0;
      held_err <= 1'b0;
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
      r1          <= 9'd0;
      retry       <= '0;
      fault_count <= 8'd0;
`endif
    end else begin
      if (grant) begin
        op_a  <= req_a[{win, 3'b000} +: 8];
        op_b  <= req_b[{win, 3'b000} +: 8];
        op_id <= win;
        rr    <= win + 2'd1;
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
        retry <= '0;
`endif
      end
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
      if (state == EXEC1) r1 <= add_sum;
      if (state == EXEC2) begin
        if (!mismatch) begin
          held_sum <= r1;
          held_id  <= op_id;
          held_err <= 1'b0;
        end else begin
          if (fault_count != 8'hFF) fault_count <= fault_count + 8'd1;
          if (retry_left) begin
            retry <= retry + RETRY_W'(1);
          end else begin
            held_sum <= r1;
            held_id  <= op_id;
            held_err <= 1'b1;
          end
        end
      end
`else
      if (state == EXEC1) begin
        held_sum <= add_sum;
        held_id  <= op_id;
        held_err <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_addr8u_share_ctrl.sv
// tb/tb_addr8u_share_ctrl.sv - scoreboard bench for addr8u_share_ctrl with a behavioural adder
`timescale 1ns/1ps
module tb_addr8u_share_ctrl;

  localparam int MAX_RETRY = 2;
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [1:0] id;
    logic [8:0] sum;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = 4'b0000;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [8:0]  add_sum;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [8:0]  rsp_sum;
  logic        rsp_err;
  logic        busy;
  logic [7:0]  fault_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   exp_faults = 0;

  // Adder model: bit 0 is flipped while the swapped operand pair is presented and budget remains
  logic [7:0] cor_a = 8'h00;
  logic [7:0] cor_b = 8'h00;
  int         corrupt_lim = 0;
  int         ex2_cnt = 0;
  logic       swapped;

  always #5 clk = ~clk;

  assign swapped = (cor_a != cor_b) && (add_a == cor_b) && (add_b == cor_a);
  assign add_sum = ({1'b0, add_a} + {1'b0, add_b}) ^ {8'd0, swapped && (ex2_cnt < corrupt_lim)};

  always @(posedge clk) if (swapped) ex2_cnt <= ex2_cnt + 1;

  addr8u_share_ctrl #(.MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_err(rsp_err), .busy(busy), .fault_cnt(fault_cnt)
  );

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0000; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_sum !== 9'd0)     begin n_fail++; $display("FAIL reset_rsp_sum: got %h want 000", rsp_sum); end
    n_checks++; if (rsp_id !== 2'd0)      begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    n_checks++; if (rsp_err !== 1'b0)     begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    n_checks++; if ({add_a, add_b} !== 16'd0) begin n_fail++; $display("FAIL reset_add_ops: got %h/%h want 00/00", add_a, add_b); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (fault_cnt !== 8'd0)   begin n_fail++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
  endtask

  task automatic test_single();
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    set_op(2, 8'h64, 8'h32); req_valid = 4'b0100; rsp_ready = 1'b1;
    sb.push_back('{2'd2, 9'h096, 1'b0});
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if ({add_a, add_b} !== 16'h6432) begin n_fail++; $display("FAIL single_exec1_ops: got %h/%h want 64/32", add_a, add_b); end
    n_checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_busy: busy=%b ready=%b want 1/0000", busy, req_ready); end
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    n_checks++; if (lat != LAT) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", lat, LAT); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL single_sb: response with empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum || rsp_err !== e.err) begin
        n_fail++; $display("FAIL single_rsp: got v=%b id=%0d sum=%h err=%b want v=1 id=%0d sum=%h err=%b", rsp_valid, rsp_id, rsp_sum, rsp_err, e.id, e.sum, e.err);
      end
    end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_after: busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
    n_checks++; if (rsp_sum !== 9'h096 || add_a !== 8'd0) begin n_fail++; $display("FAIL single_hold: sum=%h add_a=%h want 096/00", rsp_sum, add_a); end
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [1:0] w;
    int grants = 0, rsps = 0, last = -1, cyc = 0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_a = {8'hFF, 8'h2A, 8'h1B, 8'h0C};
    req_b = {8'hFF, 8'h30, 8'h21, 8'h12};
    req_valid = 4'hF; rsp_ready = 1'b1;
    while (rsps < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (rsp_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin n_fail++; $display("FAIL rr_sb: response with empty scoreboard"); end
        else begin
          e = sb.pop_front();
          if (rsp_id !== e.id || rsp_sum !== e.sum || rsp_err !== e.err) begin
            n_fail++; $display("FAIL rr_rsp%0d: got id=%0d sum=%h err=%b want id=%0d sum=%h err=%b", rsps, rsp_id, rsp_sum, rsp_err, e.id, e.sum, e.err);
          end
        end
        rsps++;
      end
      if (req_ready !== 4'b0000 && grants < 5) begin
        w = 2'(grants % 4);
        n_checks++; if (req_ready !== (4'b0001 << w)) begin n_fail++; $display("FAIL rr_order%0d: got %b want %b", grants, req_ready, 4'b0001 << w); end
        if (last >= 0) begin
          n_checks++; if (cyc - last != LAT + 1) begin n_fail++; $display("FAIL rr_spacing%0d: got %0d want %0d", grants, cyc - last, LAT + 1); end
        end
        last = cyc;
        sb.push_back('{w, model_sum(req_a[8*w +: 8], req_b[8*w +: 8]), 1'b0});
        grants++;
        if (grants == 5) begin @(posedge clk); #1 req_valid = 4'b0000; end
      end
    end
    n_checks++; if (rsps != 5) begin n_fail++; $display("FAIL rr_count: got %0d responses want 5", rsps); end
  endtask

  task automatic test_rsp_stall();
    exp_t e;
    int   cyc = 0;
    @(posedge clk); #1;
    set_op(1, 8'h7F, 8'h81); req_valid = 4'b0010; rsp_ready = 1'b0;
    sb.push_back('{2'd1, 9'h100, 1'b0});
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_grant: got %b want 0010", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0001;
    while (rsp_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 9'h100 || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b sum=%h id=%0d ready=%b want 1/100/1/0000", k, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      @(posedge clk); #1;
      if (k == 1) req_valid = 4'b0000;
      if (k == 3) rsp_ready = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL stall_sb: response with empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum || rsp_err !== e.err) begin
        n_fail++; $display("FAIL stall_rsp: got v=%b id=%0d sum=%h err=%b want v=1 id=%0d sum=%h err=%b", rsp_valid, rsp_id, rsp_sum, rsp_err, e.id, e.sum, e.err);
      end
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_idle: busy=%b ready=%b want 0/0000", busy, req_ready); end
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   cyc = 0, stray = 0;
    @(posedge clk); #1;
    set_op(0, 8'h11, 8'h22); req_valid = 4'b0001;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL abort_grant: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0000;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || add_a !== 8'h11) begin n_fail++; $display("FAIL abort_exec1: busy=%b add_a=%h want 1/11", busy, add_a); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_faults = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 8'd0 || rsp_sum !== 9'd0) begin
      n_fail++; $display("FAIL abort_state: busy=%b v=%b add_a=%h sum=%h want 0/0/00/000", busy, rsp_valid, add_a, rsp_sum);
    end
    repeat (6) begin @(negedge clk); if (rsp_valid === 1'b1) stray++; end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d stray responses want 0", stray); end
    @(posedge clk); #1;
    set_op(3, 8'h05, 8'h06); set_op(0, 8'hA0, 8'h0B); req_valid = 4'b1001;
    sb.push_back('{2'd0, 9'h0AB, 1'b0});
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL abort_priority: got %b want 0001", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0000;
    while (rsp_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL abort_sb: response with empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum || rsp_err !== e.err) begin
        n_fail++; $display("FAIL abort_rsp: got v=%b id=%0d sum=%h err=%b want v=1 id=%0d sum=%h err=%b", rsp_valid, rsp_id, rsp_sum, rsp_err, e.id, e.sum, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fault(input int n_corrupt, input int exp_lat, input logic exp_err, input int new_faults);
    exp_t e;
    int   lat = 0;
    @(posedge clk); #1;
    cor_a = 8'h12; cor_b = 8'h34; corrupt_lim = ex2_cnt + n_corrupt;
    set_op(2, 8'h12, 8'h34); req_valid = 4'b0100; rsp_ready = 1'b1;
    exp_faults += new_faults;
    sb.push_back('{2'd2, 9'h046, exp_err});
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL fault_grant: got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = 4'b0000;
    do begin @(negedge clk); lat++; end while (rsp_valid !== 1'b1 && lat < 40);
    n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL fault_latency: got %0d want %0d", lat, exp_lat); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL fault_sb: response with empty scoreboard"); end
    else begin
      e = sb.pop_front();
      if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_sum !== e.sum || rsp_err !== e.err) begin
        n_fail++; $display("FAIL fault_rsp: got v=%b id=%0d sum=%h err=%b want v=1 id=%0d sum=%h err=%b", rsp_valid, rsp_id, rsp_sum, rsp_err, e.id, e.sum, e.err);
      end
    end
    n_checks++; if (fault_cnt !== 8'(exp_faults)) begin n_fail++; $display("FAIL fault_cnt: got %0d want %0d", fault_cnt, exp_faults); end
    @(posedge clk); #1 corrupt_lim = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rsp_stall();
    test_reset_abort();
`ifdef ADDR8U_TEMPORAL_REDUNDANCY_EN
    test_fault(1000, 7, 1'b1, 3);
    test_fault(1, 5, 1'b0, 1);
`else
    test_fault(1000, 2, 1'b0, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/addr8u_share_ctrl.md
ADDR8U_SHARE_CTRL -- requirements
Module: addr8u_share_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_RETRY, default 2, the number of re-executions allowed after a redundancy mismatch before an error is reported.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 4 bits: request valid per requester 0..3.
REQ-005 The block SHALL have port req_a, input, 32 bits: operand A of requester i on bits [8i+7:8i].
REQ-006 The block SHALL have port req_b, input, 32 bits: operand B of requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port req_ready, output, 4 bits: one-hot grant; the request is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-008 The block SHALL have ports add_a and add_b, output, 8 bits each: operands driven to the shared external addr8u adder.
REQ-009 The block SHALL have port add_sum, input, 9 bits: combinational sum returned by the adder.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the response handshake.
REQ-011 The block SHALL have ports rsp_id, output, 2 bits; rsp_sum, output, 9 bits; and rsp_err, output, 1 bit: the requester index, the result and the fault flag.
REQ-012 The block SHALL have ports busy, output, 1 bit: state is not IDLE; and fault_cnt, output, 8 bits: the mismatch count.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC1, EXEC2, RESP; one transaction is in flight at a time.
REQ-014 In IDLE with any req_valid bit set, req_ready SHALL be asserted combinationally for one winner chosen round-robin, starting at the rr pointer.
REQ-015 On acceptance, the block SHALL register the operands and the winner index, set rr to winner+1 mod 4, clear the retry count and go to EXEC1.
REQ-016 req_ready SHALL be 0 in every state other than IDLE.
REQ-017 In EXEC1, add_a SHALL equal opA and add_b SHALL equal opB; add_sum is captured into r1 at the cycle end.
REQ-018 In EXEC2, add_a SHALL equal opB and add_b SHALL equal opA (operands swapped); add_sum is captured into r2.
REQ-019 Outside EXEC1 and EXEC2, add_a and add_b SHALL be 0, to limit adder toggling.
REQ-020 The sum SHALL be a 9-bit unsigned value with no truncation, e.g. 255+255 gives 9'h1FE.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_sum, rsp_id and rsp_err SHALL be held stable until rsp_ready is 1.
REQ-022 The cycle after the RESP handshake, the FSM SHALL be in IDLE; a new grant is possible in that IDLE cycle.
REQ-023 When rsp_ready is already 1 as rsp_valid rises, the RESP state SHALL last exactly one cycle.
REQ-024 With no requests pending, the FSM SHALL stay in IDLE and rr SHALL be unchanged.
REQ-025 Deassertion of req_valid by a requester that has not been granted SHALL be legal and SHALL be ignored.
REQ-026 In all states other than RESP, rsp_valid SHALL be 0; rsp_sum, rsp_id and rsp_err SHALL keep the last response.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE and set rr=0, retry=0, r1=r2=0, fault_cnt=0.
REQ-028 After reset, req_ready=0 until the first IDLE evaluation; rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_err=0, add_a=add_b=0, busy=0.
REQ-029 Reset in any state SHALL abort the transaction in flight, and no response SHALL be issued for it.
REQ-030 After reset, requester 0 SHALL have the highest priority.

Configuration
REQ-031 Macro ADDR8U_TEMPORAL_REDUNDANCY_EN SHALL select the redundancy mode.
REQ-032 When the macro is defined, the sequence SHALL be EXEC1 -> EXEC2 -> compare r1 vs r2.
REQ-033 If r1 equals r2, the block SHALL go to RESP with rsp_sum=r1 and rsp_err=0.
REQ-034 On a mismatch, fault_cnt SHALL increment, saturating at 255.
REQ-035 After a mismatch with retry < MAX_RETRY, retry SHALL increment and the FSM SHALL go back to EXEC1.
REQ-036 After a mismatch with retry = MAX_RETRY, the block SHALL go to RESP with rsp_sum=r1 and rsp_err=1.
REQ-037 With the macro defined, latency from acceptance to rsp_valid SHALL be 3 cycles fault-free.
REQ-038 When the macro is undefined, the sequence SHALL be EXEC1 -> RESP, skipping EXEC2.
REQ-039 With the macro undefined, latency SHALL be 2 cycles, rsp_err SHALL be 0 and fault_cnt SHALL be constant 0.

Verification
REQ-040 Scenario: requester 2 sends A=8'h64, B=8'h32 with rsp_ready=1. Required: rsp_valid 3 cycles later (2 cycles with the macro undefined), rsp_sum=9'h096, rsp_id=2, rsp_err=0.
REQ-041 Scenario: req_valid=4'hF held, rsp_ready=1, starting from reset. Required: grants in order 0,1,2,3,0; operand pair 255+255 gives rsp_sum=9'h1FE.
REQ-042 Scenario: macro defined; the bench model corrupts add_sum bit 0 only when add_a=opB (EXEC2), with MAX_RETRY=2. Required: 3 mismatches, fault_cnt=3, rsp_err=1, rsp_sum=r1.
REQ-043 Scenario: transient corruption in the first EXEC2 only. Required: one retry, rsp_err=0, correct sum, fault_cnt=1, latency 5 cycles.
REQ-044 Scenario: rsp_ready held 0 for 4 cycles during RESP. Required: rsp_valid and rsp_sum stable for all 4 cycles, no new grant.
REQ-045 Scenario: rst asserted in EXEC1. Required: next cycle busy=0, rsp_valid=0, add_a=0; the aborted request produces no response.
